prm_edge_query_seq: RTL and testbench

- Frame sequencer that drives the shared code bus of the PRM edge-checker bank (prm_oblgc_chk* instances, one per roadmap edge) and collects their edge_mask outputs.
- Accepts a stream of 15-bit obstacle codes per frame and presents each code to the bank. ORs the returned per-edge mask vector into a blocked-edge accumulator.
- On frame end, emits the accumulated mask and the obstacle count to the roadmap update logic over a valid/ready handshake.

---
 rtl/prm_seq_pkg.sv | 14 +
 rtl/prm_tag_pipe.sv | 32 +++
 rtl/prm_edge_query_seq.sv | 75 +++++++
 tb/tb_prm_edge_query_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/prm_seq_pkg.sv
// prm_seq_pkg: shared state encoding and bank constants for PRM bank sequencers
package prm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int PRM_CODE_W    = 15;
    localparam int PRM_NUM_EDGES = 256;

endpackage

// File: rtl/prm_tag_pipe.sv
// prm_tag_pipe: LAT-deep valid shift register; empty means no tag is queued behind the output stage
module prm_tag_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tag_in,
    output logic tag_out,
    output logic empty
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign tag_out = tag_in;
            assign empty   = 1'b1;
        end else begin : g_sr
            logic [LAT-1:0] sr;
            logic [LAT:0]   q;
            assign q       = {sr, tag_in};
            assign tag_out = q[LAT];
            assign empty   = ~|q[LAT-1:0];
            // shift tags one stage per cycle toward the output
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sr <= '0;
                else     sr <= q[LAT-1:0];
            end
        end
    endgenerate

endmodule

// File: rtl/prm_edge_query_seq.sv
// prm_edge_query_seq: drives obstacle codes to the edge-checker bank and ORs returned masks per frame
module prm_edge_query_seq
    import prm_seq_pkg::*;
#(
    parameter int NUM_EDGES = PRM_NUM_EDGES,
    parameter int CODE_W    = PRM_CODE_W,
    parameter int CHK_LAT   = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic [CODE_W-1:0]    obs_code,
    input  logic                 obs_last,
    output logic [CODE_W-1:0]    chk_code,
    output logic                 chk_valid,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NUM_EDGES-1:0] res_mask,
    output logic [CNT_W-1:0]     res_count,
    output logic                 busy
);

    seq_state_t           state;
    logic [NUM_EDGES-1:0] acc;
    logic [CNT_W-1:0]     count;
    logic                 accept;
    logic                 fold;
    logic                 drained;

    assign obs_ready = ~rst & (state == IDLE || state == RUN);
    assign accept    = obs_valid & obs_ready;
    assign res_valid = state == DONE;
    assign busy      = state != IDLE;
    assign res_mask  = acc;
    assign res_count = count;

    // tag follows each live chk_code through the bank so only real samples get folded
    prm_tag_pipe #(.LAT(CHK_LAT)) u_tag (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (chk_valid),
        .tag_out (fold),
        .empty   (drained)
    );

    // frame FSM, code register, saturating counter and mask accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            chk_code  <= '0;
            chk_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
        end else begin
            chk_valid <= accept;
            if (accept) chk_code <= obs_code;
            if (accept && count != '1) count <= count + 1'b1;
            if (fold) acc <= acc | chk_mask;
            case (state)
                IDLE, RUN: if (accept) state <= obs_last ? DRAIN : RUN;
                DRAIN:     if (drained) state <= DONE;
                DONE: if (res_ready) begin
                    state <= IDLE;
                    acc   <= '0;
                    count <= '0;
                end
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// tb_prm_edge_query_seq: directed frames on two sequencers (CHK_LAT 1 and 3) with a result scoreboard
module tb_prm_edge_query_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ov[2], ordy[2], ol[2], cv[2], rv[2], rr[2], bz[2];
    logic [14:0] oc[2], cc[2];
    logic [7:0]  cm[2], rm[2];
    logic [2:0]  rc[2];
    logic [7:0]  tbl[16];
    logic [7:0]  ba, bb1, bb2, bb3;
    logic [10:0] q0[$], q1[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    prm_edge_query_seq #(.NUM_EDGES(8), .CODE_W(15), .CHK_LAT(1), .CNT_W(3)) u_a (
        .clk(clk), .rst(rst), .obs_valid(ov[0]), .obs_ready(ordy[0]), .obs_code(oc[0]),
        .obs_last(ol[0]), .chk_code(cc[0]), .chk_valid(cv[0]), .chk_mask(cm[0]),
        .res_valid(rv[0]), .res_ready(rr[0]), .res_mask(rm[0]), .res_count(rc[0]), .busy(bz[0])
    );

    prm_edge_query_seq #(.NUM_EDGES(8), .CODE_W(15), .CHK_LAT(3), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .obs_valid(ov[1]), .obs_ready(ordy[1]), .obs_code(oc[1]),
        .obs_last(ol[1]), .chk_code(cc[1]), .chk_valid(cv[1]), .chk_mask(cm[1]),
        .res_valid(rv[1]), .res_ready(rr[1]), .res_mask(rm[1]), .res_count(rc[1]), .busy(bz[1])
    );

    // bank models: table lookup on live codes, 8'hFF garbage on bubbles
    always @(posedge clk) begin
        ba  <= cv[0] ? tbl[cc[0][3:0]] : 8'hFF;
        bb1 <= cv[1] ? tbl[cc[1][3:0]] : 8'hFF;
        bb2 <= bb1;
        bb3 <= bb2;
    end
    assign cm[0] = ba;
    assign cm[1] = bb3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [7:0] m, input logic [2:0] c);
        if (d == 0) q0.push_back({m, c});
        else        q1.push_back({m, c});
    endtask

    task automatic put(input int d, input logic [14:0] code, input logic last);
        ov[d] = 1'b1;
        oc[d] = code;
        ol[d] = last;
        chk("obs_ready_accept", ordy[d], 1);
        tick;
        ov[d] = 1'b0;
        ol[d] = 1'b0;
    endtask

    task automatic wait_res(input int d);
        int n = 0;
        while (!rv[d] && n < 20) begin
            tick;
            n++;
        end
        chk("res_valid_wait", rv[d], 1);
    endtask

    task automatic mon(input int d);
        logic [10:0] e;
        int          sz;
        if (rv[d] && rr[d]) begin
            sz = d == 0 ? q0.size() : q1.size();
            if (sz == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected dut%0d: got mask %0h count %0d, required no result", d, rm[d], rc[d]);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("res_mask_dut%0d", d), rm[d], e[10:3]);
                chk($sformatf("res_count_dut%0d", d), rc[d], e[2:0]);
            end
        end
    endtask

    // monitor: compare each handshaken result against the scoreboard
    always @(negedge clk) if (!rst) begin
        mon(0);
        mon(1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] sat[10];
        sat = '{15'h0001, 15'h0002, 15'h0001, 15'h0004, 15'h0001,
                15'h0002, 15'h0006, 15'h0001, 15'h0002, 15'h0004};
        for (int i = 0; i < 16; i++) tbl[i] = 8'h00;
        tbl[1] = 8'h01; tbl[2] = 8'h10; tbl[3] = 8'h80; tbl[4] = 8'h05; tbl[5] = 8'h40;
        tbl[6] = 8'h02; tbl[7] = 8'h08; tbl[8] = 8'h20; tbl[9] = 8'h04;
        for (int d = 0; d < 2; d++) begin
            ov[d] = 1'b0; ol[d] = 1'b0; oc[d] = '0; rr[d] = 1'b1;
        end
        #1 rst = 1'b1;
        #2;
        chk("rst_obs_ready", ordy[0], 0);
        chk("rst_busy", bz[0], 0);
        chk("rst_res_valid", rv[0], 0);
        chk("rst_chk_valid", cv[0], 0);
        chk("rst_chk_code", cc[0], 0);
        chk("rst_res_mask", rm[0], 0);
        chk("rst_res_count", rc[0], 0);
        #9 rst = 1'b0;
        tick;
        // single-code frame, latency 1+CHK_LAT
        push(0, 8'h05, 3'd1);
        put(0, 15'h1234, 1'b1);
        chk("single_chk_code", cc[0], 15'h1234);
        chk("single_busy", bz[0], 1);
        chk("single_rv_t0", rv[0], 0);
        tick;
        chk("single_rv_t1", rv[0], 0);
        tick;
        chk("single_rv_t2", rv[0], 1);
        tick;
        // three-code burst without bubbles
        push(0, 8'h91, 3'd3);
        put(0, 15'h7FF1, 1'b0);
        put(0, 15'h0A02, 1'b0);
        put(0, 15'h5553, 1'b1);
        chk("burst_drain_ready", ordy[0], 0);
        wait_res(0);
        tick;
        // backpressure then immediate next frame with cleared accumulator
        rr[0] = 1'b0;
        push(0, 8'h40, 3'd1);
        put(0, 15'h0015, 1'b1);
        wait_res(0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_res_valid", rv[0], 1);
            chk("bp_res_mask", rm[0], 8'h40);
            chk("bp_obs_ready", ordy[0], 0);
        end
        rr[0] = 1'b1;
        tick;
        push(0, 8'h02, 3'd1);
        put(0, 15'h0016, 1'b1);
        wait_res(0);
        tick;
        // bubbles on the CHK_LAT=3 instance: accepts at cycles 0, 2, 5
        push(1, 8'h2C, 3'd3);
        put(1, 15'h0007, 1'b0);
        tick;
        put(1, 15'h0008, 1'b0);
        tick;
        tick;
        put(1, 15'h0009, 1'b1);
        wait_res(1);
        tick;
        // async reset in the middle of a frame
        put(0, 15'h0011, 1'b0);
        put(0, 15'h0022, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_obs_ready", ordy[0], 0);
        chk("arst_busy", bz[0], 0);
        chk("arst_chk_valid", cv[0], 0);
        chk("arst_chk_code", cc[0], 0);
        chk("arst_res_valid", rv[0], 0);
        chk("arst_res_mask", rm[0], 0);
        chk("arst_res_count", rc[0], 0);
        #1 rst = 1'b0;
        tick;
        push(0, 8'h05, 3'd1);
        put(0, 15'h1234, 1'b1);
        wait_res(0);
        tick;
        // counter saturation at 3'd7 while masks keep folding
        push(0, 8'h17, 3'd7);
        for (int i = 0; i < 10; i++) put(0, sat[i], i == 9);
        wait_res(0);
        tick;
        tick;
        chk("sb_drained_a", q0.size(), 0);
        chk("sb_drained_b", q1.size(), 0);
        chk("idle_busy_a", bz[0], 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
